// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, functs, mnemonic enum, encoder FSM states
// and the field payload carried from the handshake into the word encoder.
package mips_isa_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [3:0] {
      MN_ADD  = 4'd0,
      MN_SUB  = 4'd1,
      MN_AND  = 4'd2,
      MN_OR   = 4'd3,
      MN_SLT  = 4'd4,
      MN_LW   = 4'd5,
      MN_SW   = 4'd6,
      MN_BEQ  = 4'd7,
      MN_ADDI = 4'd8,
      MN_J    = 4'd9,
      MN_ORI  = 4'd10,
      MN_BNE  = 4'd11
   } mnem_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } enc_state_e;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

endpackage

// File: rtl/mips_instr_field_encode.sv
// Combinational assembly of one 32-bit MIPS word from a mnemonic and its fields;
// mnemonics 12-15 raise o_illegal and yield a zero word.
module mips_instr_field_encode
   import mips_isa_pkg::*;
(
   input  logic [3:0]        i_mnem,
   input  instr_fields_t     i_fields,
   output logic [WORD_W-1:0] o_word,
   output logic              o_illegal
);

   always_comb begin
      o_word    = '0;
      o_illegal = 1'b0;
      case (i_mnem)
         MN_ADD:  o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd, 5'd0, FUNCT_ADD};
         MN_SUB:  o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd, 5'd0, FUNCT_SUB};
         MN_AND:  o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd, 5'd0, FUNCT_AND};
         MN_OR:   o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd, 5'd0, FUNCT_OR};
         MN_SLT:  o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd, 5'd0, FUNCT_SLT};
         MN_LW:   o_word = {OP_LW,   i_fields.rs, i_fields.rt, i_fields.imm};
         MN_SW:   o_word = {OP_SW,   i_fields.rs, i_fields.rt, i_fields.imm};
         MN_BEQ:  o_word = {OP_BEQ,  i_fields.rs, i_fields.rt, i_fields.imm};
         MN_ADDI: o_word = {OP_ADDI, i_fields.rs, i_fields.rt, i_fields.imm};
         MN_ORI:  o_word = {OP_ORI,  i_fields.rs, i_fields.rt, i_fields.imm};
         MN_BNE:  o_word = {OP_BNE,  i_fields.rs, i_fields.rt, i_fields.imm};
         MN_J:    o_word = {OP_J,    i_fields.target};
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction loader: accepts symbolic instructions over valid/ready, encodes them
// and writes them to consecutive imem word addresses, one registered write per accept.
module mips_instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            mnem,
   input  logic [4:0]            rs,
   input  logic [4:0]            rt,
   input  logic [4:0]            rd,
   input  logic [15:0]           imm,
   input  logic [25:0]           target,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WORD_W-1:0]     imem_wd,
   output logic                  busy,
   output logic                  full,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

   enc_state_e              r_state;
   enc_state_e              w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [CNT_W-1:0]        r_count;
   logic [CNT_W-1:0]        w_count_inc;
   logic                    r_in_ready;
   logic                    r_busy;
   logic                    r_full;
   logic                    r_err;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [WORD_W-1:0]       r_wd;
   instr_fields_t           w_fields;
   logic [WORD_W-1:0]       w_word;
   logic                    w_illegal;
   logic                    w_accept;
   logic                    w_write;

   assign w_fields = '{rs: rs, rt: rt, rd: rd, imm: imm, target: target};

   mips_instr_field_encode u_field_encode (
      .i_mnem    (mnem),
      .i_fields  (w_fields),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   // A handshake coinciding with start is dropped; one coinciding with finish still lands.
   assign w_accept    = in_valid && (r_state == ST_LOAD) && !start;
   assign w_write     = w_accept && !w_illegal;
   assign w_count_inc = r_count + CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ST_LOAD;
      end else begin
         if (w_write && (w_count_inc == CAPACITY)) w_state_nxt = ST_FULL;
         if (finish && (r_state != ST_IDLE))      w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_ptr      <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_err      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wd       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == ST_LOAD);
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_we       <= w_write;
         if (start) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
         end else begin
            if (w_write) begin
               r_addr  <= r_ptr;
               r_wd    <= w_word;
               r_ptr   <= r_ptr + ADDR_WIDTH'(1);
               r_count <= w_count_inc;
               if (w_count_inc == CAPACITY) r_full <= 1'b1;
            end
            if (w_accept && w_illegal) r_err <= 1'b1;
         end
      end
   end

   assign in_ready   = r_in_ready;
   assign busy       = r_busy;
   assign full       = r_full;
   assign error      = r_err;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wd    = r_wd;
   assign word_count = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: a 64-word and a 4-word instance share directed stimulus
// and are checked every cycle against a session-level model plus literal encodings.
module tb_mips_instr_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, finish, in_valid;
   logic [3:0]  mnem;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;

   logic        in_ready6, imem_we6, busy6, full6, error6;
   logic [5:0]  imem_addr6;
   logic [31:0] imem_wd6;
   logic [6:0]  word_count6;

   logic        in_ready2, imem_we2, busy2, full2, error2;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_wd2;
   logic [2:0]  word_count2;

   mips_instr_encoder #(.ADDR_WIDTH(6)) dut6 (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready6), .mnem(mnem),
      .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .imem_we(imem_we6), .imem_addr(imem_addr6), .imem_wd(imem_wd6),
      .busy(busy6), .full(full6), .error(error6), .word_count(word_count6)
   );

   mips_instr_encoder #(.ADDR_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready2), .mnem(mnem),
      .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wd(imem_wd2),
      .busy(busy2), .full(full2), .error(error2), .word_count(word_count2)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0=idle 1=loading 2=full, one entry per instance.
   int          opc_tab   [0:11] = '{0, 0, 0, 0, 0, 35, 43, 4, 8, 2, 13, 5};
   int          funct_tab [0:4]  = '{32, 34, 36, 37, 42};
   int          m_cap   [2] = '{64, 4};
   int          m_mode  [2];
   int          m_count [2];
   bit          m_err   [2];
   bit          m_we    [2];
   int          m_addr  [2];
   logic [31:0] m_wd    [2];
   bit          model_ok = 1'b0;

   function automatic logic [32:0] model_enc(input int m, input logic [4:0] s, t, d,
                                             input logic [15:0] i, input logic [25:0] tg);
      logic [31:0] w;
      if (m > 11) return {1'b1, 32'h0};
      if (m < 5)       w = {6'd0, s, t, d, 5'd0, 6'(funct_tab[m])};
      else if (m == 9) w = {6'd2, tg};
      else             w = {6'(opc_tab[m]), s, t, i};
      return {1'b0, w};
   endfunction

   always @(posedge clk) begin
      logic [32:0] e;
      for (int k = 0; k < 2; k++) begin
         bit ready;
         ready = (m_mode[k] == 1);
         if (reset) begin
            m_mode[k] = 0; m_count[k] = 0; m_err[k] = 0;
            m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 32'h0;
         end else if (start) begin
            m_mode[k] = 1; m_count[k] = 0; m_err[k] = 0; m_we[k] = 0;
         end else begin
            m_we[k] = 0;
            if (in_valid && ready) begin
               e = model_enc(int'(mnem), rs, rt, rd, imm, target);
               if (e[32]) m_err[k] = 1;
               else begin
                  m_we[k]   = 1;
                  m_addr[k] = m_count[k] % m_cap[k];
                  m_wd[k]   = e[31:0];
                  m_count[k]++;
                  if (m_count[k] == m_cap[k]) m_mode[k] = 2;
               end
            end
            if (finish) m_mode[k] = 0;
         end
      end
      model_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("d6_ready", 64'(in_ready6),   64'(m_mode[0] == 1));
         chk("d6_busy",  64'(busy6),       64'(m_mode[0] != 0));
         chk("d6_full",  64'(full6),       64'(m_count[0] == m_cap[0]));
         chk("d6_error", 64'(error6),      64'(m_err[0]));
         chk("d6_we",    64'(imem_we6),    64'(m_we[0]));
         chk("d6_addr",  64'(imem_addr6),  64'(m_addr[0]));
         chk("d6_wd",    64'(imem_wd6),    64'(m_wd[0]));
         chk("d6_count", 64'(word_count6), 64'(m_count[0]));
         chk("d2_ready", 64'(in_ready2),   64'(m_mode[1] == 1));
         chk("d2_busy",  64'(busy2),       64'(m_mode[1] != 0));
         chk("d2_full",  64'(full2),       64'(m_count[1] == m_cap[1]));
         chk("d2_error", 64'(error2),      64'(m_err[1]));
         chk("d2_we",    64'(imem_we2),    64'(m_we[1]));
         chk("d2_addr",  64'(imem_addr2),  64'(m_addr[1]));
         chk("d2_wd",    64'(imem_wd2),    64'(m_wd[1]));
         chk("d2_count", 64'(word_count2), 64'(m_count[1]));
      end
   end

   task automatic drive(input bit st, fin, rst, v, input int m, a_rs, a_rt, a_rd, a_imm, a_tg);
      start = st; finish = fin; reset = rst; in_valid = v;
      mnem = 4'(m); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd);
      imm = 16'(a_imm); target = 26'(a_tg);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_start();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic offer(input int m, a_rs, a_rt, a_rd, a_imm, a_tg);
      drive(0, 0, 0, 1, m, a_rs, a_rt, a_rd, a_imm, a_tg);
   endtask

   task automatic expect_write(input string nm, input int a, input logic [31:0] w);
      chk({nm, "_we"},   64'(imem_we6),   64'(1));
      chk({nm, "_addr"}, 64'(imem_addr6), 64'(a));
      chk({nm, "_wd"},   64'(imem_wd6),   64'(w));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      mnem = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_ready", 64'(in_ready6), 64'(0));
      chk("rst_we",    64'(imem_we6),  64'(0));
      chk("rst_wd",    64'(imem_wd6),  64'(0));
      chk("rst_count", 64'(word_count6), 64'(0));
      idle();

      // single ADD
      do_start();
      chk("start_ready", 64'(in_ready6), 64'(1));
      offer(0, 1, 2, 3, 0, 0);
      expect_write("add", 0, 32'h00221820);
      chk("add_count", 64'(word_count6), 64'(1));
      idle();

      // back-to-back stream
      do_start();
      offer(5, 0, 2, 0, 4, 0);
      expect_write("lw", 0, 32'h8C020004);
      offer(10, 4, 5, 0, 'h00FF, 0);
      expect_write("ori", 1, 32'h348500FF);
      offer(9, 0, 0, 0, 0, 'h10);
      expect_write("j", 2, 32'h08000010);
      offer(11, 1, 2, 0, 'hFFFF, 0);
      expect_write("bne", 3, 32'h1422FFFF);
      idle();

      // illegal mnemonic between two ADDs
      do_start();
      offer(0, 4, 5, 6, 0, 0);
      offer(13, 1, 1, 1, 1, 1);
      chk("ill_we",    64'(imem_we6), 64'(0));
      chk("ill_error", 64'(error6),   64'(1));
      offer(0, 7, 8, 9, 0, 0);
      expect_write("add2", 1, 32'h00E84820);
      chk("ill_sticky", 64'(error6), 64'(1));
      idle();
      do_start();
      chk("ill_clear", 64'(error6), 64'(0));

      // fill the 4-word instance with five offers
      for (int i = 0; i < 5; i++) begin
         offer(1, i, i + 1, i + 2, 0, 0);
         if (i == 3) begin
            chk("fill_full",  64'(full2),       64'(1));
            chk("fill_ready", 64'(in_ready2),   64'(0));
            chk("fill_count", 64'(word_count2), 64'(4));
         end
      end
      chk("fill_fifth_we", 64'(imem_we2), 64'(0));
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fill_finish_busy", 64'(busy2), 64'(0));

      // finish with a handshake, then start with a handshake
      do_start();
      drive(0, 1, 0, 1, 0, 1, 2, 3, 0, 0);
      expect_write("fin", 0, 32'h00221820);
      chk("fin_ready", 64'(in_ready6), 64'(0));
      chk("fin_busy",  64'(busy6),     64'(0));
      do_start();
      drive(1, 0, 0, 1, 0, 3, 3, 3, 0, 0);
      chk("st_hs_we",    64'(imem_we6),    64'(0));
      chk("st_hs_count", 64'(word_count6), 64'(0));
      offer(2, 1, 2, 3, 0, 0);
      expect_write("and", 0, 32'h00221824);

      // reset right after an accept, then reset coinciding with a handshake
      offer(4, 1, 2, 3, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst2_we",    64'(imem_we6),    64'(0));
      chk("rst2_addr",  64'(imem_addr6),  64'(0));
      chk("rst2_count", 64'(word_count6), 64'(0));
      chk("rst2_busy",  64'(busy6),       64'(0));
      idle();
      do_start();
      drive(0, 0, 1, 1, 0, 1, 2, 3, 0, 0);
      chk("rst3_we",    64'(imem_we6), 64'(0));
      chk("rst3_wd",    64'(imem_wd6), 64'(0));
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
